fust_s_param: RTL and testbench
===============================

// Module: fust_s_param
// PURPOSE
//  Parametrised scalar functional-unit status table: one row per scalar FU (ALU, SLS, BR, ...),
//  each row holding one dispatched op, its two source-producer tags and a speculation bit.
//  Sits between dispatch and the scalar FUs. It adds writeback wakeup, a valid/ready issue
//  handshake and selective flush of speculative rows.
// PARAMETERS
//  NUM_FU   3   number of scalar FUs / table rows
//  TAG_W    2   producer-tag width; tag 0 = operand ready, tag k = FU k-1 (needs NUM_FU < 2**TAG_W)
//  ROW_W    64  width of the packed fust_s_row_t payload (op, rd, rs1, rs2, imm)
// PORTS
//  CLK           in   1              clock
//  nRST          in   1              async active-low reset
//  disp_en       in   1              dispatch request
//  disp_fu       in   NUM_FU idx     target row (clog2(NUM_FU) bits)
//  disp_row      in   ROW_W          op payload
//  disp_t1       in   TAG_W          producer tag, source 1
//  disp_t2       in   TAG_W          producer tag, source 2
//  disp_spec     in   1              op is under an unresolved branch
//  disp_ready    out  NUM_FU         row i free (combinational from busy only)
//  wb_valid      in   1              producer writeback this cycle
//  wb_tag        in   TAG_W          tag of the writing producer
//  flush         in   1              branch mispredict: kill speculative rows
//  resolved      in   1              branch resolved correctly: clear spec bits
//  iss_valid     out  NUM_FU         row i ready to issue
//  iss_ready     in   NUM_FU         FU i accepts
//  iss_row       out  NUM_FU*ROW_W   row payloads (valid only with iss_valid)
//  out_busy      out  NUM_FU         row occupied
//  out_t1/out_t2 out  NUM_FU*TAG_W   current tags per row
// BEHAVIOUR
//  Reset (nRST=0, asynchronous): all rows IDLE; busy, spec, t1, t2, payload = 0; iss_valid = 0.
//  Per-row FSM: IDLE -> WAIT (dispatch, a tag != 0) | READY (dispatch, both tags 0 after bypass);
//   WAIT -> READY when both tags reach 0; READY -> IDLE on iss_valid & iss_ready (issue fire).
//  Dispatch accepted iff disp_en & ~busy[disp_fu]; a dispatch to a busy row is dropped (caller
//   must check disp_ready). Row written at the next edge; iss_valid no earlier than next cycle.
//  Wakeup: wb_valid clears every stored t1/t2 equal to wb_tag at the next edge (wb_tag 0 ignored).
//   Same-cycle bypass: a dispatched tag equal to wb_tag is stored as 0.
//  iss_valid[i] = READY state (registered); once asserted, held with payload stable until fire.
//  Flush: at next edge every busy row with spec=1 -> IDLE, including READY rows whose issue fires
//   that cycle (fire wins: FU has accepted). A same-cycle dispatch with disp_spec=1 is dropped;
//   disp_spec=0 is accepted. Non-spec rows unaffected.
//  Resolved (without flush): all spec bits cleared; a same-cycle dispatch stores spec=0.
//   flush & resolved together: flush takes priority, resolved has no further effect.
//  Dispatch into a row freed by issue in the same cycle is not allowed (disp_ready excludes it).
//  Tags and payload of IDLE rows are don't-care externally but held at 0 internally.
// STRUCTURE
//  Package datapath_pkg: fust_s_row_t, fu_scalar_t, row-state enum {IDLE, WAIT, READY},
//   TAG_READY = '0 constant.
//  Sub-module fust_s_row: one row (FSM, tags, spec, payload, wakeup/flush logic); the top
//   instantiates NUM_FU of it in a generate loop and decodes disp_fu.
// TESTING
//  1 Reset mid-WAIT: dispatch row0 t1=2, drop nRST -> out_busy=0, iss_valid=0 immediately.
//  2 Dispatch row1 t1=3,t2=0; wb_tag=3 two cycles later -> iss_valid[1] the cycle after wb.
//  3 Dispatch row0 t1=1 with wb_valid,wb_tag=1 same cycle -> out_t1[0]=0, iss_valid[0] next cycle.
//  4 Rows 0 (spec) and 2 (non-spec) busy, flush -> out_busy=3'b100; flush+disp_spec dispatch dropped.
//  5 Row2 READY, iss_ready low 3 cycles -> iss_valid/iss_row stable; ready high -> busy[2]=0 next.
//  6 Spec row, resolved=1 then flush=1 later -> row survives and issues normally.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types for the scalar functional-unit status table.
package datapath_pkg;

    // Producer tag value meaning "operand already available".
    localparam int TAG_READY = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } row_state_e;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_SLS = 2'd1,
        FU_BR  = 2'd2
    } fu_scalar_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [9:0]  rsvd;
    } fust_s_row_t;

    localparam int FUST_S_ROW_W = $bits(fust_s_row_t);

endpackage

// File: rtl/fust_s_row.sv
// One row of the scalar FU status table: holds a dispatched op until both
// source tags are woken, then offers it to the FU until accepted.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | row free; tags, spec and payload held at zero
// WAIT  | op stored, at least one source tag still pending
// READY | both tags clear; iss_valid asserted, payload stable until fire
module fust_s_row
    import datapath_pkg::*;
#(
    parameter int TAG_W = 2,
    parameter int ROW_W = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             disp_we,
    input  logic [ROW_W-1:0] disp_row,
    input  logic [TAG_W-1:0] disp_t1,
    input  logic [TAG_W-1:0] disp_t2,
    input  logic             disp_spec,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             flush,
    input  logic             resolved,
    input  logic             iss_ready,
    output logic             busy,
    output logic             iss_valid,
    output logic [ROW_W-1:0] row,
    output logic [TAG_W-1:0] t1,
    output logic [TAG_W-1:0] t2
);

    localparam logic [TAG_W-1:0] TAG_ZERO = TAG_W'(TAG_READY);

    row_state_e       state_q, state_d;
    logic             spec_q, spec_d;
    logic [TAG_W-1:0] t1_q, t1_d;
    logic [TAG_W-1:0] t2_q, t2_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             busy_q, busy_d;
    logic             iss_valid_q, iss_valid_d;
    logic             wb_en;

    // Next-state: dispatch with bypass, wakeup, issue fire, then flush kill on top.
    always_comb begin
        state_d = state_q;
        spec_d  = spec_q & ~(resolved & ~flush);
        t1_d    = t1_q;
        t2_d    = t2_q;
        row_d   = row_q;
        wb_en   = wb_valid && (wb_tag != TAG_ZERO);

        case (state_q)
            IDLE: begin
                // A speculative op arriving during a mispredict is already dead.
                if (disp_we && !(flush && disp_spec)) begin
                    t1_d    = (wb_en && disp_t1 == wb_tag) ? TAG_ZERO : disp_t1;
                    t2_d    = (wb_en && disp_t2 == wb_tag) ? TAG_ZERO : disp_t2;
                    row_d   = disp_row;
                    spec_d  = disp_spec & ~resolved;
                    state_d = (t1_d == TAG_ZERO && t2_d == TAG_ZERO) ? READY : WAIT;
                end
            end
            WAIT: begin
                if (wb_en && t1_q == wb_tag) t1_d = TAG_ZERO;
                if (wb_en && t2_q == wb_tag) t2_d = TAG_ZERO;
                if (t1_d == TAG_ZERO && t2_d == TAG_ZERO) state_d = READY;
            end
            READY: begin
                if (iss_ready) begin
                    state_d = IDLE;
                    spec_d  = 1'b0;
                    t1_d    = TAG_ZERO;
                    t2_d    = TAG_ZERO;
                    row_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Fire and kill both end in IDLE, so a firing speculative row needs no special case.
        if (flush && spec_q && state_q != IDLE) begin
            state_d = IDLE;
            spec_d  = 1'b0;
            t1_d    = TAG_ZERO;
            t2_d    = TAG_ZERO;
            row_d   = '0;
        end

        busy_d      = (state_d != IDLE);
        iss_valid_d = (state_d == READY);
    end

    // Row state registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            spec_q      <= 1'b0;
            t1_q        <= '0;
            t2_q        <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            iss_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            spec_q      <= spec_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            row_q       <= row_d;
            busy_q      <= busy_d;
            iss_valid_q <= iss_valid_d;
        end
    end

    assign busy      = busy_q;
    assign iss_valid = iss_valid_q;
    assign row       = row_q;
    assign t1        = t1_q;
    assign t2        = t2_q;

endmodule

// File: rtl/fust_s_param.sv
// Scalar functional-unit status table: NUM_FU rows, one per scalar FU.
// Decodes the dispatch target and fans shared wakeup/flush controls to every row.
module fust_s_param
    import datapath_pkg::*;
#(
    parameter int NUM_FU = 3,
    parameter int TAG_W  = 2,
    parameter int ROW_W  = FUST_S_ROW_W,
    parameter int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    disp_en,
    input  logic [IDX_W-1:0]        disp_fu,
    input  logic [ROW_W-1:0]        disp_row,
    input  logic [TAG_W-1:0]        disp_t1,
    input  logic [TAG_W-1:0]        disp_t2,
    input  logic                    disp_spec,
    output logic [NUM_FU-1:0]       disp_ready,
    input  logic                    wb_valid,
    input  logic [TAG_W-1:0]        wb_tag,
    input  logic                    flush,
    input  logic                    resolved,
    output logic [NUM_FU-1:0]       iss_valid,
    input  logic [NUM_FU-1:0]       iss_ready,
    output logic [NUM_FU*ROW_W-1:0] iss_row,
    output logic [NUM_FU-1:0]       out_busy,
    output logic [NUM_FU*TAG_W-1:0] out_t1,
    output logic [NUM_FU*TAG_W-1:0] out_t2
);

    logic [NUM_FU-1:0] disp_we;

    // Busy rows never take a dispatch, which also covers rows firing this cycle.
    assign disp_ready = ~out_busy;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_row
        assign disp_we[i] = disp_en && (disp_fu == IDX_W'(i)) && !out_busy[i];

        fust_s_row #(
            .TAG_W (TAG_W),
            .ROW_W (ROW_W)
        ) u_row (
            .CLK       (CLK),
            .nRST      (nRST),
            .disp_we   (disp_we[i]),
            .disp_row  (disp_row),
            .disp_t1   (disp_t1),
            .disp_t2   (disp_t2),
            .disp_spec (disp_spec),
            .wb_valid  (wb_valid),
            .wb_tag    (wb_tag),
            .flush     (flush),
            .resolved  (resolved),
            .iss_ready (iss_ready[i]),
            .busy      (out_busy[i]),
            .iss_valid (iss_valid[i]),
            .row       (iss_row[i*ROW_W +: ROW_W]),
            .t1        (out_t1[i*TAG_W +: TAG_W]),
            .t2        (out_t2[i*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_fust_s_param.sv
// Self-checking bench for fust_s_param: scoreboard of expected issues,
// one task per scenario, inputs driven and outputs sampled on the falling edge.
module tb_fust_s_param;

    localparam int NUM_FU = 3;
    localparam int TAG_W  = 2;
    localparam int ROW_W  = 64;

    logic                    CLK;
    logic                    nRST;
    logic                    disp_en;
    logic [1:0]              disp_fu;
    logic [ROW_W-1:0]        disp_row;
    logic [TAG_W-1:0]        disp_t1;
    logic [TAG_W-1:0]        disp_t2;
    logic                    disp_spec;
    logic [NUM_FU-1:0]       disp_ready;
    logic                    wb_valid;
    logic [TAG_W-1:0]        wb_tag;
    logic                    flush;
    logic                    resolved;
    logic [NUM_FU-1:0]       iss_valid;
    logic [NUM_FU-1:0]       iss_ready;
    logic [NUM_FU*ROW_W-1:0] iss_row;
    logic [NUM_FU-1:0]       out_busy;
    logic [NUM_FU*TAG_W-1:0] out_t1;
    logic [NUM_FU*TAG_W-1:0] out_t2;

    typedef struct {
        int               fu;
        logic [ROW_W-1:0] payload;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt;
    int   err_cnt;

    fust_s_param #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .ROW_W(ROW_W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .disp_en    (disp_en),
        .disp_fu    (disp_fu),
        .disp_row   (disp_row),
        .disp_t1    (disp_t1),
        .disp_t2    (disp_t2),
        .disp_spec  (disp_spec),
        .disp_ready (disp_ready),
        .wb_valid   (wb_valid),
        .wb_tag     (wb_tag),
        .flush      (flush),
        .resolved   (resolved),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_row    (iss_row),
        .out_busy   (out_busy),
        .out_t1     (out_t1),
        .out_t2     (out_t2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    // Present one dispatch for a single cycle; side controls are left to the caller.
    task automatic dispatch(input int fu, input logic [ROW_W-1:0] p,
                            input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b,
                            input logic s);
        disp_en   = 1'b1;
        disp_fu   = 2'(fu);
        disp_row  = p;
        disp_t1   = a;
        disp_t2   = b;
        disp_spec = s;
        tick();
        disp_en   = 1'b0;
        disp_row  = '0;
        disp_t1   = '0;
        disp_t2   = '0;
        disp_spec = 1'b0;
    endtask

    // Wait (bounded) for the row to offer, score the offered payload, then fire it.
    task automatic issue_and_score(input int fu);
        int   waited;
        exp_t e;
        waited = 0;
        while (iss_valid[fu] !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        vec_cnt++;
        if (iss_valid[fu] !== 1'b1) begin
            err_cnt++;
            $display("FAIL issue_timeout row%0d: iss_valid=%b, required 1", fu, iss_valid[fu]);
            return;
        end
        vec_cnt++;
        if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL unexpected_issue row%0d: scoreboard empty", fu);
        end else begin
            e = exp_q.pop_front();
            if (e.fu != fu || iss_row[fu*ROW_W +: ROW_W] !== e.payload) begin
                err_cnt++;
                $display("FAIL issue_payload row%0d: got %h, required row%0d %h",
                         fu, iss_row[fu*ROW_W +: ROW_W], e.fu, e.payload);
            end
        end
        iss_ready[fu] = 1'b1;
        tick();
        iss_ready[fu] = 1'b0;
        vec_cnt++;
        if (out_busy[fu] !== 1'b0 || iss_valid[fu] !== 1'b0) begin
            err_cnt++;
            $display("FAIL issue_free row%0d: busy=%b iss_valid=%b, required 0/0",
                     fu, out_busy[fu], iss_valid[fu]);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #12;
        vec_cnt++;
        if (out_busy !== 3'b000 || iss_valid !== 3'b000 || disp_ready !== 3'b111) begin
            err_cnt++;
            $display("FAIL reset_state: busy=%b iss_valid=%b ready=%b, required 000/000/111",
                     out_busy, iss_valid, disp_ready);
        end
        tick();
        nRST = 1'b1;
        tick();
        dispatch(0, 64'hAAAA_0000_0000_0001, 2'd2, 2'd0, 1'b0);
        vec_cnt++;
        if (out_busy !== 3'b001 || out_t1[1:0] !== 2'd2 || iss_valid !== 3'b000) begin
            err_cnt++;
            $display("FAIL reset_pre_wait: busy=%b t1=%0d iss_valid=%b, required 001/2/000",
                     out_busy, out_t1[1:0], iss_valid);
        end
        #2 nRST = 1'b0;
        #1;
        vec_cnt++;
        if (out_busy !== 3'b000 || iss_valid !== 3'b000 || out_t1 !== '0 || iss_row !== '0) begin
            err_cnt++;
            $display("FAIL reset_async: busy=%b iss_valid=%b t1=%h, required all zero",
                     out_busy, iss_valid, out_t1);
        end
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_wakeup();
        exp_q.push_back('{1, 64'h1111_2222_3333_4444});
        dispatch(1, 64'h1111_2222_3333_4444, 2'd3, 2'd0, 1'b0);
        vec_cnt++;
        if (out_t1[3:2] !== 2'd3 || iss_valid[1] !== 1'b0) begin
            err_cnt++;
            $display("FAIL wakeup_wait: t1=%0d iss_valid=%b, required 3/0", out_t1[3:2], iss_valid[1]);
        end
        tick();
        wb_valid = 1'b1;
        wb_tag   = 2'd3;
        tick();
        wb_valid = 1'b0;
        wb_tag   = 2'd0;
        vec_cnt++;
        if (out_t1[3:2] !== 2'd0 || iss_valid[1] !== 1'b1) begin
            err_cnt++;
            $display("FAIL wakeup_ready: t1=%0d iss_valid=%b, required 0/1", out_t1[3:2], iss_valid[1]);
        end
        issue_and_score(1);
    endtask

    task automatic test_bypass();
        exp_q.push_back('{0, 64'h0BAD_CAFE_0000_0003});
        wb_valid = 1'b1;
        wb_tag   = 2'd1;
        dispatch(0, 64'h0BAD_CAFE_0000_0003, 2'd1, 2'd0, 1'b0);
        wb_valid = 1'b0;
        wb_tag   = 2'd0;
        vec_cnt++;
        if (out_t1[1:0] !== 2'd0 || iss_valid[0] !== 1'b1) begin
            err_cnt++;
            $display("FAIL bypass: t1=%0d iss_valid=%b, required 0/1", out_t1[1:0], iss_valid[0]);
        end
        issue_and_score(0);
    endtask

    task automatic test_flush();
        dispatch(0, 64'h5BEC_0000_0000_0000, 2'd1, 2'd0, 1'b1);
        exp_q.push_back('{2, 64'h2222_0000_0000_0002});
        dispatch(2, 64'h2222_0000_0000_0002, 2'd0, 2'd0, 1'b0);
        vec_cnt++;
        if (out_busy !== 3'b101) begin
            err_cnt++;
            $display("FAIL flush_setup: busy=%b, required 101", out_busy);
        end
        flush = 1'b1;
        dispatch(1, 64'hDEAD_0000_0000_0001, 2'd0, 2'd0, 1'b1);
        flush = 1'b0;
        vec_cnt++;
        if (out_busy !== 3'b100 || out_t1[1:0] !== 2'd0) begin
            err_cnt++;
            $display("FAIL flush_kill: busy=%b t1_row0=%0d, required 100/0", out_busy, out_t1[1:0]);
        end
        exp_q.push_back('{1, 64'h1111_0000_0000_0005});
        flush = 1'b1;
        dispatch(1, 64'h1111_0000_0000_0005, 2'd0, 2'd0, 1'b0);
        flush = 1'b0;
        vec_cnt++;
        if (out_busy !== 3'b110 || disp_ready !== 3'b001) begin
            err_cnt++;
            $display("FAIL flush_nonspec_disp: busy=%b ready=%b, required 110/001", out_busy, disp_ready);
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 3; c++) begin
            vec_cnt++;
            if (iss_valid[2] !== 1'b1 || iss_row[2*ROW_W +: ROW_W] !== 64'h2222_0000_0000_0002) begin
                err_cnt++;
                $display("FAIL stall_hold cyc%0d: iss_valid=%b row=%h, required 1/2222000000000002",
                         c, iss_valid[2], iss_row[2*ROW_W +: ROW_W]);
            end
            tick();
        end
        issue_and_score(2);
        issue_and_score(1);
    endtask

    task automatic test_resolved();
        exp_q.push_back('{0, 64'h7777_0000_0000_0006});
        dispatch(0, 64'h7777_0000_0000_0006, 2'd0, 2'd2, 1'b1);
        resolved = 1'b1;
        exp_q.push_back('{1, 64'h8888_0000_0000_0007});
        dispatch(1, 64'h8888_0000_0000_0007, 2'd3, 2'd0, 1'b1);
        resolved = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vec_cnt++;
        if (out_busy !== 3'b011) begin
            err_cnt++;
            $display("FAIL resolved_survive: busy=%b, required 011", out_busy);
        end
        wb_valid = 1'b1;
        wb_tag   = 2'd2;
        tick();
        wb_valid = 1'b0;
        wb_tag   = 2'd0;
        issue_and_score(0);
        wb_valid = 1'b1;
        wb_tag   = 2'd3;
        tick();
        wb_valid = 1'b0;
        wb_tag   = 2'd0;
        issue_and_score(1);
    endtask

    task automatic test_back_to_back();
        // Drop on a busy row, flush priority over resolved, wb_tag 0 ignored.
        exp_q.push_back('{0, 64'h9999_0000_0000_0008});
        dispatch(0, 64'h9999_0000_0000_0008, 2'd1, 2'd0, 1'b0);
        dispatch(0, 64'hEEEE_0000_0000_0009, 2'd0, 2'd0, 1'b0);
        vec_cnt++;
        if (out_t1[1:0] !== 2'd1 || iss_valid[0] !== 1'b0) begin
            err_cnt++;
            $display("FAIL busy_drop: t1=%0d iss_valid=%b, required 1/0", out_t1[1:0], iss_valid[0]);
        end
        dispatch(2, 64'h3333_0000_0000_000A, 2'd0, 2'd3, 1'b1);
        flush    = 1'b1;
        resolved = 1'b1;
        tick();
        flush    = 1'b0;
        resolved = 1'b0;
        vec_cnt++;
        if (out_busy !== 3'b001) begin
            err_cnt++;
            $display("FAIL flush_over_resolved: busy=%b, required 001", out_busy);
        end
        wb_valid = 1'b1;
        wb_tag   = 2'd0;
        tick();
        vec_cnt++;
        if (iss_valid[0] !== 1'b0 || out_t1[1:0] !== 2'd1) begin
            err_cnt++;
            $display("FAIL wb_tag0_ignored: iss_valid=%b t1=%0d, required 0/1", iss_valid[0], out_t1[1:0]);
        end
        wb_tag = 2'd1;
        tick();
        wb_valid = 1'b0;
        wb_tag   = 2'd0;
        issue_and_score(0);
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        nRST      = 1'b0;
        disp_en   = 1'b0;
        disp_fu   = '0;
        disp_row  = '0;
        disp_t1   = '0;
        disp_t2   = '0;
        disp_spec = 1'b0;
        wb_valid  = 1'b0;
        wb_tag    = '0;
        flush     = 1'b0;
        resolved  = 1'b0;
        iss_ready = '0;

        test_reset();
        test_wakeup();
        test_bypass();
        test_flush();
        test_stall();
        test_resolved();
        test_back_to_back();

        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
